serial_adder: RTL

Parametrised bit-serial adder/subtractor that reuses one full-adder cell and a carry flip-flop to add or subtract two WIDTH-bit operands, LSB first, in WIDTH clock cycles. It is the sequential, multi-bit successor to the team's single-bit full-adder cells and sits in the datapath wherever area matters more than latency. A start/busy/done handshake frames each operation. It reports sum, carry-out and signed overflow.

---
 rtl/serial_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Latency: WIDTH cycles from the accept edge to the done pulse; one result per WIDTH+1 cycles.
// Backpressure: none; start is honoured only while idle and dropped (not queued) while busy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, sub, a, b, ci  request with operation select, operands, carry/borrow-in (sampled on accept)
//   busy, done          operation in progress; one-cycle pulse when results update
//   s, co, ovf          registered result, carry out of MSB, signed overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // The single full-adder cell, always looking at the current LSBs.
  logic fa_sum;
  logic fa_co;
  assign fa_sum = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_co  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // Result register with the new sum bit shifted in at the MSB; after WIDTH
  // shifts bit 0 of the operands has landed in bit 0 of the result.
  logic [WIDTH-1:0] res_shift;
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_shift = fa_sum;
    end else begin : g_wn
      assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          // Subtraction is a + ~b + ~borrow, so invert B and the carry-in up front.
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~ci : ci;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          s_d     = res_shift;
          co_d    = fa_co;
          // carry_q here is the carry into the MSB stage.
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule
